dilithium_vy_loader: RTL and testbench

DILITHIUM_VY_LOADER -- requirements
Module: dilithium_vy_loader

---
 rtl/dilithium_vy_loader_if.sv | 34 +++
 rtl/dilithium_vy_loader.sv | 199 +++++++++++++++++++
 tb/tb_dilithium_vy_loader.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dilithium_vy_loader_if.sv
// Loader-side bus bundle: start/status, vector memory read port,
// outbound core stream and inbound result stream.
interface dilithium_vy_loader_if #(
  parameter int W  = 64,
  parameter int AW = 12
);
  logic          go;
  logic [31:0]   msg_len;
  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic [W-1:0]  mem_rdata;
  logic          core_valid;
  logic [W-1:0]  core_data;
  logic          core_ready;
  logic          res_valid;
  logic [W-1:0]  res_data;
  logic          res_ready;
  logic          busy;
  logic          done;
  logic          accepted;
  logic [31:0]   cycle_count;

  modport master (
    input  go, msg_len, mem_rdata, core_ready, res_valid, res_data,
    output mem_addr, mem_rd, core_valid, core_data, res_ready,
           busy, done, accepted, cycle_count
  );

  modport slave (
    output go, msg_len, mem_rdata, core_ready, res_valid, res_data,
    input  mem_addr, mem_rd, core_valid, core_data, res_ready,
           busy, done, accepted, cycle_count
  );
endinterface

// File: rtl/dilithium_vy_loader.sv
// Streams rho, c, z, t1, msg_len, msg and h from vector memory into the verify core.
// Define VY_LOADER_CYCLE_CNT_EN to build the go-to-done cycle counter. W must be a power of two >= 32.
module dilithium_vy_loader #(
  parameter int W          = 64,
  parameter int SEED_WORDS = 4,
  parameter int Z_WORDS    = 80,
  parameter int T1_WORDS   = 80,
  parameter int H_WORDS    = 2,
  parameter int AW         = 12
) (
  input logic                  clk,
  input logic                  rst,
  dilithium_vy_loader_if.master bus
);
  localparam int BPW     = W / 8;
  localparam int LOG_BPW = $clog2(BPW);
  localparam logic [AW-1:0] H_BASE   = AW'(2 * SEED_WORDS + Z_WORDS + T1_WORDS);
  localparam logic [AW-1:0] MSG_BASE = AW'(2 * SEED_WORDS + Z_WORDS + T1_WORDS + H_WORDS);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_RHO    = 4'd1;
  localparam logic [3:0] S_C      = 4'd2;
  localparam logic [3:0] S_Z      = 4'd3;
  localparam logic [3:0] S_T1     = 4'd4;
  localparam logic [3:0] S_MLEN   = 4'd5;
  localparam logic [3:0] S_MSG    = 4'd6;
  localparam logic [3:0] S_H      = 4'd7;
  localparam logic [3:0] S_RESULT = 4'd8;
  localparam logic [3:0] S_DONE   = 4'd9;

  logic [3:0]    state_q, state_d;
  logic [31:0]   sec_cnt_q, sec_cnt_d;
  logic [31:0]   msg_len_q, msg_len_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          infl_vld_q, infl_vld_d;
  logic          infl_const_q, infl_const_d;
  logic [W-1:0]  infl_word_q, infl_word_d;
  logic [W-1:0]  buf0_q, buf0_d, buf1_q, buf1_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          accepted_q, accepted_d;

  logic [32:0]        msg_round;
  logic [31:0]        msg_words, sec_len;
  logic [LOG_BPW-1:0] tail_rem;
  logic [W-1:0]       tail_mask, push_data;
  logic [2:0]         occ_after;
  logic               pop, issue, sec_last, h_issued, in_stream, busy;

  assign msg_round = {1'b0, msg_len_q} + 33'(BPW - 1);
  assign msg_words = 32'(msg_round >> LOG_BPW);
  assign tail_rem  = msg_len_q[LOG_BPW-1:0];
  // MSB-first bytes: keep the top tail_rem bytes of the final message word.
  assign tail_mask = (tail_rem == '0) ? '1 : ~({W{1'b1}} >> {tail_rem, 3'b000});

  always_comb begin
    case (state_q)
      S_RHO, S_C: sec_len = 32'(SEED_WORDS);
      S_Z:        sec_len = 32'(Z_WORDS);
      S_T1:       sec_len = 32'(T1_WORDS);
      S_MLEN:     sec_len = 32'd1;
      S_MSG:      sec_len = msg_words;
      S_H:        sec_len = 32'(H_WORDS);
      default:    sec_len = 32'd0;
    endcase
  end

  assign in_stream = state_q inside {S_RHO, S_C, S_Z, S_T1, S_MLEN, S_MSG, S_H};
  assign sec_last  = (sec_cnt_q == sec_len - 32'd1);
  assign h_issued  = (state_q == S_H) && (sec_cnt_q == 32'(H_WORDS));
  assign pop       = (cnt_q != 2'd0) && bus.core_ready;
  // Slot accounting includes the word still in flight and the one leaving this cycle.
  assign occ_after = {1'b0, cnt_q} + {2'b00, infl_vld_q} - {2'b00, pop};
  assign issue     = in_stream && !h_issued && (occ_after < 3'd2);
  assign push_data = infl_const_q ? infl_word_q : (bus.mem_rdata & infl_word_q);
  assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);

  always_comb begin
    // NOTE: every next-state signal gets a default here so no latch is inferred.
    state_d      = state_q;
    sec_cnt_d    = sec_cnt_q;
    msg_len_d    = msg_len_q;
    addr_d       = addr_q;
    accepted_d   = accepted_q;
    infl_vld_d   = 1'b0;
    infl_const_d = 1'b0;
    infl_word_d  = '1;
    case (state_q)
      S_IDLE: begin
        if (bus.go) begin
          state_d   = S_RHO;
          msg_len_d = bus.msg_len;
          sec_cnt_d = '0;
          addr_d    = '0;
        end
      end
      S_RHO, S_C, S_Z, S_T1, S_MLEN, S_MSG, S_H: begin
        if (issue) begin
          infl_vld_d = 1'b1;
          sec_cnt_d  = sec_cnt_q + 32'd1;
          addr_d     = addr_q + AW'(1);
          if (state_q == S_MLEN) begin
            infl_const_d = 1'b1;
            infl_word_d  = W'(msg_len_q);
            addr_d       = (msg_words == '0) ? H_BASE : MSG_BASE;
          end
          if (state_q == S_MSG && sec_last) infl_word_d = tail_mask;
          if (sec_last && state_q != S_H) begin
            sec_cnt_d = '0;
            case (state_q)
              S_RHO:   state_d = S_C;
              S_C:     state_d = S_Z;
              S_Z:     state_d = S_T1;
              S_T1:    state_d = S_MLEN;
              S_MLEN:  state_d = (msg_words == '0) ? S_H : S_MSG;
              default: begin
                state_d = S_H;
                addr_d  = H_BASE;
              end
            endcase
          end
        end
        if (h_issued && !infl_vld_q && cnt_q == 2'd0) state_d = S_RESULT;
      end
      S_RESULT: begin
        if (bus.res_valid) begin
          accepted_d = (bus.res_data == '0);
          state_d    = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    if (pop) buf0_d = buf1_q;
    if (infl_vld_q) begin
      if ((cnt_q - {1'b0, pop}) == 2'd0) buf0_d = push_data;
      else                               buf1_d = push_data;
    end
    cnt_d = cnt_q + {1'b0, infl_vld_q} - {1'b0, pop};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      sec_cnt_q    <= '0;
      msg_len_q    <= '0;
      addr_q       <= '0;
      infl_vld_q   <= 1'b0;
      infl_const_q <= 1'b0;
      infl_word_q  <= '0;
      // NOTE: the two buffer words are reset too, so core_data reads 0 out of reset.
      buf0_q       <= '0;
      buf1_q       <= '0;
      cnt_q        <= '0;
      accepted_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      sec_cnt_q    <= sec_cnt_d;
      msg_len_q    <= msg_len_d;
      addr_q       <= addr_d;
      infl_vld_q   <= infl_vld_d;
      infl_const_q <= infl_const_d;
      infl_word_q  <= infl_word_d;
      buf0_q       <= buf0_d;
      buf1_q       <= buf1_d;
      cnt_q        <= cnt_d;
      accepted_q   <= accepted_d;
    end
  end

`ifdef VY_LOADER_CYCLE_CNT_EN
  logic [31:0] cyc_cnt_q, cyc_cnt_d;
  always_comb begin
    cyc_cnt_d = cyc_cnt_q;
    if (state_q == S_IDLE && bus.go) cyc_cnt_d = '0;
    else if (busy)                   cyc_cnt_d = cyc_cnt_q + 32'd1;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cyc_cnt_q <= '0;
    else     cyc_cnt_q <= cyc_cnt_d;
  end
  assign bus.cycle_count = cyc_cnt_q;
`else
  assign bus.cycle_count = '0;
`endif

  assign bus.mem_addr   = addr_q;
  assign bus.mem_rd     = issue && (state_q != S_MLEN);
  assign bus.core_valid = (cnt_q != 2'd0);
  assign bus.core_data  = buf0_q;
  assign bus.res_ready  = (state_q == S_RESULT);
  assign bus.busy       = busy;
  assign bus.done       = (state_q == S_DONE);
  assign bus.accepted   = accepted_q;
endmodule

// File: tb/tb_dilithium_vy_loader.sv
// Scoreboard bench for dilithium_vy_loader: expected stream queued at go, checked per core beat.
module tb_dilithium_vy_loader;
  localparam int W        = 64;
  localparam int AW       = 12;
  localparam int S        = 4;
  localparam int ZW       = 80;
  localparam int TW       = 80;
  localparam int HW       = 2;
  localparam int H_BASE   = 2 * S + ZW + TW;
  localparam int MSG_BASE = H_BASE + HW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dilithium_vy_loader_if #(.W(W), .AW(AW)) bus ();

  dilithium_vy_loader #(
    .W(W), .SEED_WORDS(S), .Z_WORDS(ZW), .T1_WORDS(TW), .H_WORDS(HW), .AW(AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [W-1:0] mem [0:(1<<AW)-1];
  logic [W-1:0] exp_q[$];
  int vectors = 0, miscompares = 0;
  int cyc = 0, beats = 0, first_cyc = 0, last_cyc = 0, done_cnt = 0;
  int ready_mode = 0, stall_left = 0;
  bit first_seen = 0, prev_stall = 0;
  logic [W-1:0] prev_data;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (bus.mem_rd) bus.mem_rdata <= mem[bus.mem_addr];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push_expected(input int unsigned len);
    logic [W-1:0] w;
    int nw;
    for (int i = 0; i < 2 * S + ZW + TW; i++) exp_q.push_back(mem[i]);
    exp_q.push_back(W'(len));
    nw = (len + 7) / 8;
    for (int j = 0; j < nw; j++) begin
      w = mem[MSG_BASE + j];
      for (int b = 0; b < 8; b++)
        if (j * 8 + b >= len) w[63 - 8 * b -: 8] = 8'h00;
      exp_q.push_back(w);
    end
    for (int k = 0; k < HW; k++) exp_q.push_back(mem[H_BASE + k]);
  endtask

  // Core stream monitor: scoreboard pop, stall stability, done pulse count.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 0;
      end else begin
        if (prev_stall) begin
          check("stall_valid", bus.core_valid, 1);
          check("stall_data", bus.core_data, prev_data);
        end
        if (bus.core_valid && bus.core_ready) begin
          if (exp_q.size() == 0) check("extra_beat", bus.core_data, 'x);
          else                   check("beat", bus.core_data, exp_q.pop_front());
          beats++;
          if (!first_seen) begin
            first_seen = 1;
            first_cyc  = cyc;
          end
          last_cyc = cyc;
        end
        prev_stall = bus.core_valid && !bus.core_ready;
        prev_data  = bus.core_data;
        if (bus.done) done_cnt++;
      end
    end
  end

  // core_ready driver: mode 0 always ready, mode 1 toggling with random 3-cycle stalls.
  initial begin
    bus.core_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 0) begin
        bus.core_ready = 1'b1;
      end else if (stall_left > 0) begin
        bus.core_ready = 1'b0;
        stall_left--;
      end else if ($urandom_range(0, 7) == 0) begin
        bus.core_ready = 1'b0;
        stall_left = 2;
      end else begin
        bus.core_ready = ~bus.core_ready;
      end
    end
  end

  task automatic check_reset_outputs();
    check("rst_core_valid", bus.core_valid, 0);
    check("rst_core_data", bus.core_data, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_mem_rd", bus.mem_rd, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_res_ready", bus.res_ready, 0);
    check("rst_accepted", bus.accepted, 0);
    check("rst_cycle_count", bus.cycle_count, 0);
  endtask

  task automatic start_run(input int unsigned len, input int mode, output int go_cyc);
    ready_mode = mode;
    beats      = 0;
    first_seen = 0;
    push_expected(len);
    @(posedge clk);
    #1 bus.go = 1'b1;
    bus.msg_len = len;
    @(posedge clk);
    #1 bus.go = 1'b0;
    bus.msg_len = 32'hdead_beef;
    go_cyc = cyc;
  endtask

  task automatic run(input int unsigned len, input int mode, input logic [W-1:0] rv);
    int go_cyc, nexp, exp_cc;
    bit ok;
    nexp = 2 * S + ZW + TW + 1 + (len + 7) / 8 + HW;
    start_run(len, mode, go_cyc);
    check("busy_after_go", bus.busy, 1);
    check("res_ready_streaming", bus.res_ready, 0);
    ok = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (bus.core_valid) begin
        ok = 1;
        break;
      end
    end
    check("first_valid_latency", ok, 1);
    repeat (8) @(posedge clk);
    #1 bus.go = 1'b1;
    bus.msg_len = 32'd7;
    @(posedge clk);
    #1 bus.go = 1'b0;
    ok = 0;
    for (int k = 0; k < 4000; k++) begin
      @(posedge clk);
      #2;
      if (exp_q.size() == 0) begin
        ok = 1;
        break;
      end
    end
    check("drain", ok, 1);
    check("beat_count", beats, nexp);
    if (mode == 0) check("gapless_span", last_cyc - first_cyc + 1, nexp);
    repeat (5) @(posedge clk);
    #1 bus.res_valid = 1'b1;
    bus.res_data = rv;
    ok = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.res_ready) begin
        ok = 1;
        break;
      end
    end
    check("res_ready", ok, 1);
    @(posedge clk);
    #1 bus.res_valid = 1'b0;
    bus.res_data = '1;
    @(negedge clk);
`ifdef VY_LOADER_CYCLE_CNT_EN
    exp_cc = cyc - go_cyc;
`else
    exp_cc = 0;
`endif
    check("done_pulse", bus.done, 1);
    check("accepted", bus.accepted, (rv == '0) ? 1 : 0);
    check("cycle_count", bus.cycle_count, exp_cc);
    check("busy_at_done", bus.busy, 0);
    @(negedge clk);
    check("done_single_cycle", bus.done, 0);
    check("res_ready_after", bus.res_ready, 0);
    check("accepted_hold", bus.accepted, (rv == '0) ? 1 : 0);
  endtask

  task automatic abort_test();
    int go_cyc, d0;
    bit ok;
    d0 = done_cnt;
    start_run(33, 0, go_cyc);
    ok = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus.mem_rd && bus.mem_addr >= AW'(2 * S) && bus.mem_addr < AW'(2 * S + ZW)) begin
        ok = 1;
        break;
      end
    end
    check("reach_z", ok, 1);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    exp_q.delete();
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #2 check("no_done_on_abort", done_cnt, d0);
    run(33, 0, '0);
    check("done_after_restart", done_cnt, d0 + 1);
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = {$urandom, $urandom};
    bus.go        = 1'b0;
    bus.msg_len   = '0;
    bus.res_valid = 1'b0;
    bus.res_data  = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;
    run(33, 0, '0);
    run(0, 0, 64'd1);
    run(33, 1, '0);
    abort_test();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
